// File: rtl/det2_pkg.sv
// det2_pkg -- shared definitions for the 2x2 determinant feeder.
//   ELEM_W_DEF : default signed element width
//   ROW_W_DEF  : default row width (two elements packed)
//   row_w()    : row width for a given element width
//   det2_state_e : feeder FSM states (LOAD, WAIT, RESP)
package det2_pkg;

  localparam int ELEM_W_DEF = 8;
  localparam int ROW_W_DEF  = 2 * ELEM_W_DEF;
  localparam int CNT_W      = 2;   // element index 0..3
  localparam int LAT_W      = 4;   // latency counter, DET_LAT up to 15

  typedef enum logic [1:0] {
    ST_LOAD = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } det2_state_e;

  function automatic int row_w(input int ew);
    return 2 * ew;
  endfunction

endpackage

// File: rtl/det2_row_packer.sv
// det2_row_packer -- staging registers and row packing for one 2x2 matrix.
// Elements arrive row-major (a11, a12, a21, a22). The first three are staged;
// the fourth is taken straight from data_i so both rows update in one edge.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   acc_i     : element accepted this cycle
//   cnt_i     : index of the element being accepted (0..3)
//   data_i    : element value
//   l1_o      : {a11, a12}
//   l2_o      : {a21, a22}
module det2_row_packer
  import det2_pkg::*;
#(
  parameter  int ELEM_W = ELEM_W_DEF,
  localparam int ROW_W  = row_w(ELEM_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              acc_i,
  input  logic [CNT_W-1:0]  cnt_i,
  input  logic [ELEM_W-1:0] data_i,
  output logic [ROW_W-1:0]  l1_o,
  output logic [ROW_W-1:0]  l2_o
);

  logic [ELEM_W-1:0] stg0_q, stg1_q, stg2_q;
  logic [ROW_W-1:0]  l1_q, l2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stg0_q <= '0;
      stg1_q <= '0;
      stg2_q <= '0;
      l1_q   <= '0;
      l2_q   <= '0;
    end else if (acc_i) begin
      case (cnt_i)
        2'd0:    stg0_q <= data_i;
        2'd1:    stg1_q <= data_i;
        2'd2:    stg2_q <= data_i;
        default: begin
          // Rows are only ever written here, together.
          l1_q <= {stg0_q, stg1_q};
          l2_q <= {stg2_q, data_i};
        end
      endcase
    end
  end

  assign l1_o = l1_q;
  assign l2_o = l2_q;

endmodule

// File: rtl/det2_feeder.sv
// det2_feeder -- collects a 2x2 signed matrix element by element, presents
// its rows to an external determinant unit, waits DET_LAT cycles and holds
// the returned determinant until the consumer takes it.
// Optional feature: define DET2_FEEDER_ZERO_FLAG_EN to add res_zero, a
// registered flag that the captured determinant is zero.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   in_valid/in_ready     : element handshake, in_data row-major a11..a22
//   l1, l2                : rows to determinant unit ({a11,a12}, {a21,a22})
//   det_in                : determinant returned by the unit
//   res_valid/res_ready   : result handshake, res_data captured determinant
//   res_zero              : (optional) captured determinant == 0
//   busy                  : FSM not in LOAD
// DET_LAT must be in 1..15.
module det2_feeder
  import det2_pkg::*;
#(
  parameter  int ELEM_W  = ELEM_W_DEF,
  parameter  int DET_LAT = 1,
  localparam int ROW_W   = row_w(ELEM_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ELEM_W-1:0] in_data,
  output logic [ROW_W-1:0]  l1,
  output logic [ROW_W-1:0]  l2,
  input  logic [ELEM_W-1:0] det_in,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ELEM_W-1:0] res_data,
`ifdef DET2_FEEDER_ZERO_FLAG_EN
  output logic              res_zero,
`endif
  output logic              busy
);

  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(DET_LAT - 1);

  det2_state_e       state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [LAT_W-1:0]  lat_q;
  logic              res_valid_q;
  logic [ELEM_W-1:0] res_data_q;
  logic              res_zero_q;
  logic              accept;

  assign accept = in_valid && (state_q == ST_LOAD);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      cnt_q       <= '0;
      lat_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_zero_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          if (accept) begin
            if (cnt_q == 2'd3) begin
              cnt_q   <= '0;
              lat_q   <= '0;
              state_q <= ST_WAIT;
            end else begin
              cnt_q <= cnt_q + 2'd1;
            end
          end
        end
        ST_WAIT: begin
          // lat_q counts WAIT cycles from 0; the last one samples det_in.
          if (lat_q == LAT_LAST) begin
            res_data_q  <= det_in;
            res_zero_q  <= (det_in == '0);
            res_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else begin
            lat_q <= lat_q + 1'b1;
          end
        end
        ST_RESP: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            state_q     <= ST_LOAD;
          end
        end
        default: state_q <= ST_LOAD;
      endcase
    end
  end

  det2_row_packer #(.ELEM_W(ELEM_W)) u_packer (
    .clk    (clk),
    .rst    (rst),
    .acc_i  (accept),
    .cnt_i  (cnt_q),
    .data_i (in_data),
    .l1_o   (l1),
    .l2_o   (l2)
  );

  assign in_ready  = (state_q == ST_LOAD);
  assign busy      = (state_q != ST_LOAD);
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;

`ifdef DET2_FEEDER_ZERO_FLAG_EN
  assign res_zero = res_zero_q;
`else
  logic unused_zero;
  assign unused_zero = res_zero_q;
`endif

endmodule

// File: tb/tb_det2_feeder.sv
// tb_det2_feeder -- randomized self-checking bench for det2_feeder.
// The reference keeps the expected rows and result as plain values derived
// from the matrix elements; timing is checked against accept-cycle offsets.
module tb_det2_feeder;

  localparam int EW  = 8;
  localparam int LAT = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready;
  logic [EW-1:0] in_data, det_in, res_data;
  logic [2*EW-1:0] l1, l2;
  logic          res_valid, res_ready, busy;
`ifdef DET2_FEEDER_ZERO_FLAG_EN
  logic          res_zero;
`endif

  det2_feeder #(.ELEM_W(EW), .DET_LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .l1        (l1),
    .l2        (l2),
    .det_in    (det_in),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_data  (res_data),
`ifdef DET2_FEEDER_ZERO_FLAG_EN
    .res_zero  (res_zero),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // expected rows held by the determinant interface
  logic [2*EW-1:0] m_l1 = '0;
  logic [2*EW-1:0] m_l2 = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
    chk({tag, "_busy"},      32'(busy),      32'd0);
    chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    chk({tag, "_l1"},        32'(l1),        32'(m_l1));
    chk({tag, "_l2"},        32'(l2),        32'(m_l2));
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    m_l1 = '0;
    m_l2 = '0;
    chk_idle("rst");
    chk("rst_res_data", 32'(res_data), 32'd0);
`ifdef DET2_FEEDER_ZERO_FLAG_EN
    chk("rst_res_zero", 32'(res_zero), 32'd0);
`endif
  endtask

  // Feed one matrix with `gap` idle cycles between elements, return det,
  // keep res_ready low for `hold` RESP cycles, then complete the handshake.
  task automatic run_matrix(input logic [EW-1:0] e0, e1, e2, e3,
                            input int gap, input int hold,
                            input logic [EW-1:0] det);
    logic [EW-1:0] e[4];
    e = '{e0, e1, e2, e3};
    det_in = EW'($urandom);
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = e[k];
      chk("in_ready_load", 32'(in_ready), 32'd1);
      tick();
      if (k < 3) begin
        chk("rows_hold_partial", 32'({l1, l2}), 32'({m_l1, m_l2}));
        for (int g = 0; g < gap; g++) begin
          in_valid = 1'b0;
          in_data  = EW'($urandom);
          tick();
          chk_idle("gap");
        end
      end
    end
    // just past the 4th accept edge
    m_l1 = {e[0], e[1]};
    m_l2 = {e[2], e[3]};
    chk("l1", 32'(l1), 32'(m_l1));
    chk("l2", 32'(l2), 32'(m_l2));
    chk("busy_wait", 32'(busy), 32'd1);
    chk("in_ready_wait", 32'(in_ready), 32'd0);
    // junk handshakes that must be ignored outside their states
    in_valid  = 1'b1;
    in_data   = EW'($urandom);
    res_ready = 1'($urandom);
    det_in    = det;
    for (int c = 1; c <= LAT; c++) begin
      chk("res_valid_early", 32'(res_valid), 32'd0);
      tick();
    end
    // LAT+1 cycles after the 4th accept
    chk("res_valid", 32'(res_valid), 32'd1);
    chk("res_data", 32'(res_data), 32'(det));
`ifdef DET2_FEEDER_ZERO_FLAG_EN
    chk("res_zero", 32'(res_zero), 32'(det == '0));
`endif
    det_in = EW'($urandom);
    for (int h = 0; h < hold; h++) begin
      res_ready = 1'b0;
      tick();
      chk("hold_res_valid", 32'(res_valid), 32'd1);
      chk("hold_res_data", 32'(res_data), 32'(det));
      chk("hold_in_ready", 32'(in_ready), 32'd0);
    end
    res_ready = 1'b1;
    tick();
    in_valid  = 1'b0;
    res_ready = 1'b0;
    chk_idle("post");
  endtask

  initial begin
    logic [EW-1:0] r0, r1, r2, r3, d;
    int sa, sb, sc, sd;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; det_in = '0; res_ready = 1'b0;
    tick();
    do_reset();

    run_matrix(8'd2, 8'd3, 8'd4, 8'd2, 0, 0, 8'hF8);
    chk("case1_l1", 32'(l1), 32'h0203);
    chk("case1_l2", 32'(l2), 32'h0402);
    run_matrix(8'hFF, 8'd2, 8'd3, 8'd4, 0, 1, 8'hF6);
    chk("case2_l1", 32'(l1), 32'hFF02);
    run_matrix(8'd2, 8'd3, 8'd4, 8'd2, 3, 0, 8'hF8);
    chk("gap_l2", 32'(l2), 32'h0402);
    run_matrix(8'd5, 8'd6, 8'd7, 8'd8, 0, 5, 8'hFE);

    // reset after two accepts, with an accept attempted on the reset edge
    in_valid = 1'b1; in_data = 8'd7; tick();
    in_data = 8'd9; tick();
    in_data = 8'd11;
    do_reset();
    in_valid = 1'b0;
    run_matrix(8'd1, 8'd0, 8'd0, 8'd1, 0, 0, 8'd1);
    chk("rst_case_l1", 32'(l1), 32'h0100);
    chk("rst_case_l2", 32'(l2), 32'h0001);

    run_matrix(8'd2, 8'd4, 8'd1, 8'd2, 1, 2, 8'h00);
    run_matrix(8'd2, 8'd3, 8'd4, 8'd2, 0, 0, 8'hF8);

    for (int it = 0; it < 25; it++) begin
      r0 = EW'($urandom); r1 = EW'($urandom);
      r2 = EW'($urandom); r3 = EW'($urandom);
      sa = int'($signed(r0)); sb = int'($signed(r1));
      sc = int'($signed(r2)); sd = int'($signed(r3));
      d  = EW'(sa * sd - sb * sc);
      if ($urandom_range(0, 4) == 0) d = '0;
      run_matrix(r0, r1, r2, r3, int'($urandom_range(0, 2)),
                 int'($urandom_range(0, 3)), d);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
